// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared encodings for the ALU sequencer: ALU control codes, instruction
//   kinds, branch condition codes, the sequencer state enum and a helper that
//   evaluates a branch condition against the ALU flags.
// ----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_NAND = 3'b000,
        ALU_AND  = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_SHR  = 3'b011,
        ALU_MOV  = 3'b100,
        ALU_RSVD = 3'b101,
        ALU_ADD  = 3'b110,
        ALU_SUB  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        KIND_ALU    = 2'b00,  // ALU op with writeback
        KIND_CMP    = 2'b01,  // compare: SUB without writeback
        KIND_BRANCH = 2'b10,  // branch test on held ALU flags
        KIND_RSVD   = 2'b11
    } instr_kind_e;

    typedef enum logic [1:0] {
        COND_Z  = 2'b00,
        COND_C  = 2'b01,
        COND_NZ = 2'b10,
        COND_NC = 2'b11
    } br_cond_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WB    = 2'b10
    } seq_state_e;

    function automatic logic cond_met(input br_cond_e cond, input logic zf, input logic cf);
        logic met;
        unique case (cond)
            COND_Z:  met = zf;
            COND_C:  met = cf;
            COND_NZ: met = ~zf;
            default: met = ~cf;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/regfile4x8.sv
// ----------------------------------------------------------------------------
// regfile4x8
//   Four 8-bit registers with two combinational read ports (A/B operands),
//   one combinational debug read port and one synchronous write port.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset (clears R0-R3)
//     ra_addr / ra_data   read port A
//     rb_addr / rb_data   read port B
//     dbg_addr / dbg_data debug read port
//     we, wa, wd          write enable, address, data (written on rising edge)
// ----------------------------------------------------------------------------
module regfile4x8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ra_addr,
    output logic [7:0] ra_data,
    input  logic [1:0] rb_addr,
    output logic [7:0] rb_data,
    input  logic [1:0] dbg_addr,
    output logic [7:0] dbg_data,
    input  logic       we,
    input  logic [1:0] wa,
    input  logic [7:0] wd
);

    logic [7:0] regs [4];

    // NOTE: the array is small and architecturally must read zero after reset,
    // so it is reset like ordinary flops; a larger RAM would be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wa] <= wd;
        end
    end

    // Reads are combinational, so the debug port shows the old value while a
    // write is pending and the new value from the cycle after the write edge.
    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
//   Accepts one instruction at a time and sequences it through an external
//   ALU: IDLE -> ISSUE -> WB for ALU ops and compares, IDLE -> WB for branch
//   tests and illegal encodings. The external ALU registers its result and
//   flags on the edge ending ISSUE; they are consumed during WB.
//   Ports:
//     clk, rst_n                     clock, asynchronous active-low reset
//     instr_valid / instr_ready      instruction handshake (ready only in IDLE)
//     instr_kind, instr_op,
//     instr_dst, instr_src,
//     instr_use_imm, instr_imm       instruction fields
//     alu_a, alu_b, alu_control,
//     alu_execute                    operands/command to the ALU (ISSUE only)
//     alu_out, alu_zf, alu_cf        result and flags from the ALU
//     done, err, br_taken            completion pulse with status
//     dbg_sel / dbg_data             combinational register read-back
// ----------------------------------------------------------------------------
module alu_sequencer
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [1:0] instr_kind,
    input  logic [2:0] instr_op,
    input  logic [1:0] instr_dst,
    input  logic [1:0] instr_src,
    input  logic       instr_use_imm,
    input  logic [7:0] instr_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_control,
    output logic       alu_execute,
    input  logic [7:0] alu_out,
    input  logic       alu_zf,
    input  logic       alu_cf,
    output logic       done,
    output logic       err,
    output logic       br_taken,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);

    seq_state_e  state;
    instr_kind_e kind_q;
    alu_op_e     op_q;
    logic [1:0]  dst_q;
    br_cond_e    cond_q;
    logic        flags_valid;

    instr_kind_e kind_in;
    alu_op_e     op_in;
    logic        needs_alu;
    logic [7:0]  rd_a;
    logic [7:0]  rd_b;
    logic        wb_en;

    assign kind_in   = instr_kind_e'(instr_kind);
    assign op_in     = alu_op_e'(instr_op);
    assign needs_alu = (kind_in == KIND_CMP) ||
                       ((kind_in == KIND_ALU) && (op_in != ALU_RSVD));

    // Operands are read straight from the offered fields: registers only
    // change in WB, so the values captured at acceptance are current.
    regfile4x8 u_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (instr_dst),
        .ra_data  (rd_a),
        .rb_addr  (instr_src),
        .rb_data  (rd_b),
        .dbg_addr (dbg_sel),
        .dbg_data (dbg_data),
        .we       (wb_en),
        .wa       (dst_q),
        .wd       (alu_out)
    );

    assign instr_ready = (state == ST_IDLE);
    assign wb_en       = (state == ST_WB) && (kind_q == KIND_ALU) && (op_q != ALU_RSVD);

    // Branch outcome is taken from the ALU flags as they stand during WB.
    assign br_taken = done && !err && (kind_q == KIND_BRANCH) &&
                      cond_met(cond_q, alu_zf, alu_cf);

    // NOTE: every register here uses <= so all of them sample pre-edge values;
    // a blocking = would let later statements see already-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            kind_q      <= KIND_ALU;
            op_q        <= ALU_NAND;
            dst_q       <= '0;
            cond_q      <= COND_Z;
            flags_valid <= 1'b0;
            alu_execute <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            alu_execute <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        kind_q <= kind_in;
                        op_q   <= op_in;
                        dst_q  <= instr_dst;
                        cond_q <= br_cond_e'(instr_src);
                        if (needs_alu) begin
                            state       <= ST_ISSUE;
                            alu_execute <= 1'b1;
                            alu_a       <= rd_a;
                            alu_b       <= instr_use_imm ? instr_imm : rd_b;
                            alu_control <= (kind_in == KIND_CMP) ? ALU_SUB : op_in;
                        end else begin
                            // Branch tests and illegal encodings skip the ALU.
                            state <= ST_WB;
                            done  <= 1'b1;
                            err   <= (kind_in != KIND_BRANCH) || !flags_valid;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WB;
                    done  <= 1'b1;
                end
                ST_WB: begin
                    state <= ST_IDLE;
                    if ((kind_q == KIND_CMP) || ((kind_q == KIND_ALU) && (op_q == ALU_SUB))) begin
                        flags_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_sequencer
//   Self-checking bench: a registered ALU model answers the sequencer, and a
//   reference model (register array + flag state) predicts every outcome.
// ----------------------------------------------------------------------------
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [1:0] instr_kind = '0;
    logic [2:0] instr_op = '0;
    logic [1:0] instr_dst = '0;
    logic [1:0] instr_src = '0;
    logic       instr_use_imm = 1'b0;
    logic [7:0] instr_imm = '0;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_control;
    logic       alu_execute;
    logic [7:0] m_out = '0;
    logic       m_zf = 1'b0;
    logic       m_cf = 1'b0;
    logic       done, err, br_taken;
    logic [1:0] dbg_sel = '0;
    logic [7:0] dbg_data;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Reference state
    logic [7:0] ref_r [4] = '{default: 8'h00};
    logic       ref_fv = 1'b0;
    logic       ref_z = 1'b0;
    logic       ref_c = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_kind    (instr_kind),
        .instr_op      (instr_op),
        .instr_dst     (instr_dst),
        .instr_src     (instr_src),
        .instr_use_imm (instr_use_imm),
        .instr_imm     (instr_imm),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_control   (alu_control),
        .alu_execute   (alu_execute),
        .alu_out       (m_out),
        .alu_zf        (m_zf),
        .alu_cf        (m_cf),
        .done          (done),
        .err           (err),
        .br_taken      (br_taken),
        .dbg_sel       (dbg_sel),
        .dbg_data      (dbg_data)
    );

    // ALU behaviour: returns {carry, zero, result}. SUB carry is a borrow.
    function automatic logic [9:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] res;
        logic       c;
        c = 1'b0;
        case (op)
            3'd0: res = ~(a & b);
            3'd1: res = a & b;
            3'd2: res = a ^ b;
            3'd3: begin res = a >> 1; c = a[0]; end
            3'd4: res = b;
            3'd6: begin s = {1'b0, a} + {1'b0, b}; res = s[7:0]; c = s[8]; end
            3'd7: begin res = a - b; c = (a < b); end
            default: res = 8'h00;
        endcase
        return {c, (res == 8'h00), res};
    endfunction

    // External ALU: result and flags registered on the edge ending ISSUE.
    always @(posedge clk) begin
        if (alu_execute) {m_cf, m_zf, m_out} <= alu_fn(alu_control, alu_a, alu_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the reference model by one instruction and report expectations.
    task automatic model_step(input logic [1:0] k, input logic [2:0] op, input logic [1:0] dst,
                              input logic [1:0] src, input logic ui, input logic [7:0] imm,
                              output logic exp_exec, output logic exp_err, output logic exp_br,
                              output logic [7:0] exp_a, output logic [7:0] exp_b,
                              output logic [2:0] exp_ctl, output logic [7:0] old_v,
                              output logic [7:0] new_v);
        logic [9:0] r;
        logic       cond;
        old_v    = ref_r[dst];
        new_v    = old_v;
        exp_a    = ref_r[dst];
        exp_b    = ui ? imm : ref_r[src];
        exp_ctl  = (k == 2'd1) ? 3'd7 : op;
        exp_exec = (k == 2'd1) || ((k == 2'd0) && (op != 3'd5));
        exp_err  = (k == 2'd3) || ((k == 2'd0) && (op == 3'd5)) || ((k == 2'd2) && !ref_fv);
        case (src)
            2'd0: cond = ref_z;
            2'd1: cond = ref_c;
            2'd2: cond = !ref_z;
            default: cond = !ref_c;
        endcase
        exp_br = (k == 2'd2) && ref_fv && cond;
        if (exp_exec) begin
            r     = alu_fn(exp_ctl, exp_a, exp_b);
            ref_z = r[8];
            ref_c = r[9];
            if (k == 2'd0) new_v = r[7:0];
            if ((k == 2'd1) || (op == 3'd7)) ref_fv = 1'b1;
        end
        ref_r[dst] = new_v;
    endtask

    task automatic drive(input logic [1:0] k, input logic [2:0] op, input logic [1:0] dst,
                         input logic [1:0] src, input logic ui, input logic [7:0] imm);
        instr_kind = k; instr_op = op; instr_dst = dst; instr_src = src;
        instr_use_imm = ui; instr_imm = imm;
    endtask

    // Run one instruction; starts and ends just after a falling edge.
    task automatic exec(input logic [1:0] k, input logic [2:0] op, input logic [1:0] dst,
                        input logic [1:0] src, input logic ui, input logic [7:0] imm);
        logic       e_exec, e_err, e_br;
        logic [7:0] e_a, e_b, old_v, new_v;
        logic [2:0] e_ctl;
        int         n, n_exec;
        logic       stray;
        model_step(k, op, dst, src, ui, imm, e_exec, e_err, e_br, e_a, e_b, e_ctl, old_v, new_v);
        drive(k, op, dst, src, ui, imm);
        dbg_sel = dst;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        check("accept_wait", instr_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        n = 1; n_exec = 0; stray = 1'b0;
        while (!done && n < 10) begin
            if (alu_execute) begin
                n_exec++;
                check("alu_a", alu_a, e_a);
                check("alu_b", alu_b, e_b);
                check("alu_control", alu_control, e_ctl);
            end
            if (err || br_taken) stray = 1'b1;
            @(negedge clk);
            n++;
        end
        check("latency", n, e_exec ? 2 : 1);
        check("exec_count", n_exec, e_exec);
        check("status_without_done", stray, 1'b0);
        check("exec_in_wb", alu_execute, 1'b0);
        check("err", err, e_err);
        check("br_taken", br_taken, e_br);
        check("dbg_pre_write", dbg_data, old_v);
        @(negedge clk);
        check("done_single_cycle", done, 1'b0);
        check("dbg_post_write", dbg_data, new_v);
        check("ready_after", instr_ready, 1'b1);
    endtask

    task automatic check_regs();
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check($sformatf("reg_r%0d", i), dbg_data, ref_r[i]);
        end
    endtask

    task automatic do_reset();
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_ready", instr_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_exec", alu_execute, 1'b0);
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_alu_b", alu_b, 8'h00);
        check("rst_alu_control", alu_control, 3'd0);
        for (int i = 0; i < 4; i++) ref_r[i] = 8'h00;
        ref_fv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_regs();
    endtask

    // Three instructions offered with instr_valid held high throughout.
    task automatic stream3();
        logic [1:0] sk [3];
        logic [2:0] sop [3];
        logic [1:0] sd [3];
        logic [1:0] ss [3];
        logic       sui [3];
        logic [7:0] simm [3];
        int         acc_cyc [3];
        int         acc, dn, ex, idx;
        logic       pending;
        logic       e_exec, e_err, e_br;
        logic [7:0] e_a, e_b, old_v, new_v;
        logic [2:0] e_ctl;
        // MOV R1<=7; ADD R1<=R1+3; SUB R2<=R2-R1 (order-dependent chain)
        sk = '{2'd0, 2'd0, 2'd0}; sop = '{3'd4, 3'd6, 3'd7};
        sd = '{2'd1, 2'd1, 2'd2}; ss = '{2'd0, 2'd0, 2'd1};
        sui = '{1'b1, 1'b1, 1'b0}; simm = '{8'd7, 8'd3, 8'd0};
        for (int i = 0; i < 3; i++)
            model_step(sk[i], sop[i], sd[i], ss[i], sui[i], simm[i],
                       e_exec, e_err, e_br, e_a, e_b, e_ctl, old_v, new_v);
        acc = 0; dn = 0; ex = 0; idx = 0; pending = 1'b0;
        acc_cyc = '{0, 0, 0};
        drive(sk[0], sop[0], sd[0], ss[0], sui[0], simm[0]);
        instr_valid = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done) dn++;
            if (alu_execute) ex++;
            if (pending) begin
                idx++;
                if (idx < 3) drive(sk[idx], sop[idx], sd[idx], ss[idx], sui[idx], simm[idx]);
                else instr_valid = 1'b0;
                pending = 1'b0;
            end
            if (instr_valid && instr_ready) begin
                if (acc < 3) acc_cyc[acc] = cyc;
                acc++;
                pending = 1'b1;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("stream_acceptances", acc, 3);
        check("stream_done_pulses", dn, 3);
        check("stream_exec_cycles", ex, 3);
        check("stream_spacing_01", acc_cyc[1] - acc_cyc[0], 3);
        check("stream_spacing_12", acc_cyc[2] - acc_cyc[1], 3);
        check_regs();
    endtask

    task automatic reset_abort();
        logic e_exec, e_err, e_br, seen_done;
        logic [7:0] e_a, e_b, old_v, new_v;
        logic [2:0] e_ctl;
        int n;
        // ADD R3 <= R3 + 9, reset while in ISSUE
        drive(2'd0, 3'd6, 2'd3, 2'd0, 1'b1, 8'd9);
        dbg_sel = 2'd3;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        check("abort_issue_reached", alu_execute, 1'b1);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        #1;
        check("abort_exec_cleared", alu_execute, 1'b0);
        check("abort_alu_a_cleared", alu_a, 8'h00);
        check("abort_ready", instr_ready, 1'b1);
        for (int i = 0; i < 4; i++) ref_r[i] = 8'h00;
        ref_fv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (3) begin @(negedge clk); if (done) seen_done = 1'b1; end
        check("abort_no_done", seen_done, 1'b0);
        check("abort_r3", dbg_data, 8'h00);
        check("abort_ready_after", instr_ready, 1'b1);
        // Offer the same ADD across reset release: accepted on the first edge.
        rst_n = 1'b0;
        instr_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        check("first_edge_accept", alu_execute, 1'b1);
        check("first_edge_alu_b", alu_b, 8'd9);
        model_step(2'd0, 3'd6, 2'd3, 2'd0, 1'b1, 8'd9, e_exec, e_err, e_br, e_a, e_b, e_ctl, old_v, new_v);
        @(negedge clk);
        check("first_edge_done", done, 1'b1);
        @(negedge clk);
        check("first_edge_r3", dbg_data, 8'd9);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();
        // Error paths straight after reset
        exec(2'd2, 3'd0, 2'd0, 2'd0, 1'b0, 8'h00);   // branch Z, no flags yet
        exec(2'd3, 3'd0, 2'd1, 2'd2, 1'b1, 8'h55);   // reserved kind
        exec(2'd0, 3'd5, 2'd2, 2'd1, 1'b1, 8'hAA);   // reserved op
        check_regs();
        // ADD accumulation and carry-out wrap boundary
        exec(2'd0, 3'd6, 2'd1, 2'd0, 1'b1, 8'd5);
        exec(2'd0, 3'd6, 2'd1, 2'd0, 1'b1, 8'd250);
        check("r1_after_adds", ref_r[1], 8'd255);
        // MOV / CMP equal / branches
        exec(2'd0, 3'd4, 2'd2, 2'd0, 1'b1, 8'h10);
        exec(2'd1, 3'd0, 2'd2, 2'd0, 1'b1, 8'h10);
        exec(2'd2, 3'd0, 2'd0, 2'd0, 1'b0, 8'h00);   // Z -> taken
        exec(2'd2, 3'd0, 2'd0, 2'd1, 1'b0, 8'h00);   // C -> not taken
        // CMP 0 against 1 gives a borrow
        exec(2'd1, 3'd0, 2'd0, 2'd0, 1'b1, 8'h01);
        exec(2'd2, 3'd0, 2'd0, 2'd1, 1'b0, 8'h00);   // C -> taken
        exec(2'd2, 3'd0, 2'd0, 2'd2, 1'b0, 8'h00);   // !Z -> taken
        // Same register on both operands
        exec(2'd0, 3'd2, 2'd1, 2'd1, 1'b0, 8'h00);
        exec(2'd0, 3'd6, 2'd2, 2'd2, 1'b0, 8'h00);
        check_regs();
        reset_abort();
        stream3();
        // Randomized instruction mix
        for (int i = 0; i < 80; i++) begin
            int r;
            logic [1:0] k;
            r = $urandom_range(0, 9);
            k = (r < 5) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            exec(k, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        check_regs();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
